dcache_controller: RTL and testbench

//  Sequencing FSM for the one-level data cache on the single-cycle RISC-V core.

---
 rtl/dcache_controller.sv | 134 +++++++++++++
 tb/tb_dcache_controller.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_controller.sv
// Sequencing FSM for a write-through, no-write-allocate data cache with read-miss line refill.
// Optional performance counters are built only when DCACHE_PERF_EN is defined.
module dcache_controller #(
  parameter  int BLOCK_WORDS = 4,
  parameter  int CNT_W       = 32,
  localparam int IDX_W       = $clog2(BLOCK_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_read,
  input  logic             cpu_write,
  input  logic             hit,
  input  logic             mem_ready,
  output logic             stall,
  output logic             mem_read_req,
  output logic             mem_write_req,
  output logic             refill_we,
  output logic [IDX_W-1:0] refill_word,
  output logic             tag_we,
  output logic             cache_write_en,
  output logic [CNT_W-1:0] perf_rd_hit,
  output logic [CNT_W-1:0] perf_rd_miss,
  output logic [CNT_W-1:0] perf_wr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_WRITE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(BLOCK_WORDS - 1);

  state_t           state;
  logic [IDX_W-1:0] word_q;
  logic             refill_done;

  assign refill_done = (state == S_REFILL) && mem_ready && (word_q == LAST_WORD);
  assign refill_word = word_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      word_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cpu_write) begin
            state <= S_WRITE;
          end else if (cpu_read && !hit) begin
            state  <= S_REFILL;
            word_q <= '0;
          end
        end
        S_REFILL: begin
          if (mem_ready) begin
            word_q <= word_q + 1'b1;
            if (word_q == LAST_WORD) state <= S_IDLE;
          end
        end
        S_WRITE: begin
          if (mem_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs follow the current state and inputs; reset forces them quiet even with a request pending.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    stall          = 1'b0;
    mem_read_req   = 1'b0;
    mem_write_req  = 1'b0;
    refill_we      = 1'b0;
    tag_we         = 1'b0;
    cache_write_en = 1'b0;
    if (!rst) begin
      case (state)
        S_IDLE: begin
          if (cpu_write)           stall = 1'b1;
          else if (cpu_read && !hit) stall = 1'b1;
        end
        S_REFILL: begin
          stall        = 1'b1;
          mem_read_req = 1'b1;
          refill_we    = mem_ready;
          tag_we       = refill_done;
        end
        S_WRITE: begin
          mem_write_req  = 1'b1;
          stall          = !mem_ready;
          cache_write_en = mem_ready && hit;
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_PERF_EN
  logic             just_refilled;
  logic             inc_hit, inc_miss, inc_wr;
  logic [CNT_W-1:0] rd_hit_cnt, rd_miss_cnt, wr_cnt;

  // The cycle right after a refill re-serves the missed read; it is not a new hit.
  assign inc_hit  = (state == S_IDLE) && cpu_read && !cpu_write && hit && !just_refilled;
  assign inc_miss = (state == S_IDLE) && cpu_read && !cpu_write && !hit;
  assign inc_wr   = (state == S_WRITE) && mem_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      just_refilled <= 1'b0;
      rd_hit_cnt    <= '0;
      rd_miss_cnt   <= '0;
      wr_cnt        <= '0;
    end else begin
      just_refilled <= refill_done;
      if (inc_hit  && (rd_hit_cnt  != '1)) rd_hit_cnt  <= rd_hit_cnt  + 1'b1;
      if (inc_miss && (rd_miss_cnt != '1)) rd_miss_cnt <= rd_miss_cnt + 1'b1;
      if (inc_wr   && (wr_cnt      != '1)) wr_cnt      <= wr_cnt      + 1'b1;
    end
  end

  assign perf_rd_hit  = rd_hit_cnt;
  assign perf_rd_miss = rd_miss_cnt;
  assign perf_wr      = wr_cnt;
`else
  assign perf_rd_hit  = '0;
  assign perf_rd_miss = '0;
  assign perf_wr      = '0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_dcache_controller;
  localparam int BW = 4;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_read, cpu_write, hit, mem_ready;
  logic          stall, mem_read_req, mem_write_req, refill_we, tag_we, cache_write_en;
  logic [1:0]    refill_word;
  logic [CW-1:0] perf_rd_hit, perf_rd_miss, perf_wr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  dcache_controller #(.BLOCK_WORDS(BW), .CNT_W(CW)) dut (
    .clk            (clk),
    .rst            (rst),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .hit            (hit),
    .mem_ready      (mem_ready),
    .stall          (stall),
    .mem_read_req   (mem_read_req),
    .mem_write_req  (mem_write_req),
    .refill_we      (refill_we),
    .refill_word    (refill_word),
    .tag_we         (tag_we),
    .cache_write_en (cache_write_en),
    .perf_rd_hit    (perf_rd_hit),
    .perf_rd_miss   (perf_rd_miss),
    .perf_wr        (perf_wr)
  );

  always #5 clk = ~clk;

  // {stall, mem_read_req, mem_write_req, refill_we, tag_we, cache_write_en}
  function automatic logic [5:0] outs_now();
    return {stall, mem_read_req, mem_write_req, refill_we, tag_we, cache_write_en};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_read = 1'b0; cpu_write = 1'b0; hit = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    cpu_read = 1'b1; hit = 1'b0;
    @(negedge clk); tick();
    mem_ready = 1'b1;
    @(negedge clk); tick();
    mem_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (mem_read_req !== 1'b1 || refill_word !== 2'd1)
      $display("FAIL reset_setup: got req=%b word=%0d expected req=1 word=1", mem_read_req, refill_word);
    else pass_cnt++;
    rst = 1'b1;
    #2;
    total_cnt++;
    if (outs_now() !== 6'b0) $display("FAIL reset_outs: got %b expected 000000", outs_now());
    else pass_cnt++;
    total_cnt++;
    if (refill_word !== 2'd0) $display("FAIL reset_word: got %0d expected 0", refill_word);
    else pass_cnt++;
    @(posedge clk); #1;
    cpu_read = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (outs_now() !== 6'b0) $display("FAIL reset_idle: got %b expected 000000", outs_now());
    else pass_cnt++;
    tick();
  endtask

  task automatic test_read_hit();
    do_reset();
    cpu_read = 1'b1; hit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total_cnt++;
      if (outs_now() !== 6'b0) $display("FAIL read_hit_%0d: got %b expected 000000", i, outs_now());
      else pass_cnt++;
      tick();
    end
    cpu_read = 1'b0; hit = 1'b0;
  endtask

  task automatic test_read_miss();
    int         stall_cycles;
    int         tag_cnt;
    logic [1:0] tag_word;
    logic       tag_with_we;
    logic       sampled_stall;
    bit         done;
    bit         finished;
    logic [1:0] words[$];
    stall_cycles = 0; tag_cnt = 0; tag_word = 2'd0; tag_with_we = 1'b0;
    done = 0; finished = 0;
    do_reset();
    cpu_read = 1'b1; hit = 1'b0;
    for (int c = 0; c < 40; c++) begin
      hit       = done;
      mem_ready = (c > 0) && !done && (c % 2 == 0);
      @(negedge clk);
      sampled_stall = stall;
      if (stall) stall_cycles++;
      if (refill_we) words.push_back(refill_word);
      if (tag_we) begin
        tag_cnt++;
        tag_word    = refill_word;
        tag_with_we = refill_we;
        done        = 1;
      end
      tick();
      if (!sampled_stall) begin
        finished = 1;
        break;
      end
    end
    cpu_read = 1'b0; hit = 1'b0; mem_ready = 1'b0;
    total_cnt++;
    if (finished !== 1'b1) $display("FAIL miss_timeout: got stall released=%0d expected 1", finished);
    else pass_cnt++;
    total_cnt++;
    if (stall_cycles !== 9) $display("FAIL miss_stall_cycles: got %0d expected 9", stall_cycles);
    else pass_cnt++;
    total_cnt++;
    if (words.size() !== BW) $display("FAIL miss_word_count: got %0d expected %0d", words.size(), BW);
    else pass_cnt++;
    if (words.size() == BW) begin
      for (int i = 0; i < BW; i++) begin
        total_cnt++;
        if (words[i] !== 2'(i)) $display("FAIL miss_word_%0d: got %0d expected %0d", i, words[i], i);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (tag_cnt !== 1) $display("FAIL miss_tag_count: got %0d expected 1", tag_cnt);
    else pass_cnt++;
    total_cnt++;
    if (tag_word !== 2'd3 || tag_with_we !== 1'b1)
      $display("FAIL miss_tag_word: got word=%0d we=%b expected word=3 we=1", tag_word, tag_with_we);
    else pass_cnt++;
  endtask

  task automatic test_write(input logic h);
    int   stall_c;
    int   cwe_c;
    logic cwe_last;
    logic mwr_last;
    stall_c = 0; cwe_c = 0; cwe_last = 1'b0; mwr_last = 1'b0;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      cpu_write = 1'b1; hit = h; mem_ready = (c == 3);
      @(negedge clk);
      if (stall) stall_c++;
      if (cache_write_en) cwe_c++;
      if (c == 3) begin
        cwe_last = cache_write_en;
        mwr_last = mem_write_req;
      end
      tick();
    end
    cpu_write = 1'b0; hit = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (outs_now() !== 6'b0) $display("FAIL write_h%0d_idle: got %b expected 000000", h, outs_now());
    else pass_cnt++;
    tick();
    total_cnt++;
    if (stall_c !== 3) $display("FAIL write_h%0d_stall: got %0d expected 3", h, stall_c);
    else pass_cnt++;
    total_cnt++;
    if (cwe_c !== (h ? 1 : 0)) $display("FAIL write_h%0d_cwe_count: got %0d expected %0d", h, cwe_c, h ? 1 : 0);
    else pass_cnt++;
    total_cnt++;
    if (cwe_last !== h || mwr_last !== 1'b1)
      $display("FAIL write_h%0d_ready_cycle: got cwe=%b req=%b expected cwe=%b req=1", h, cwe_last, mwr_last, h);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_refill();
    logic tag_seen;
    tag_seen = 1'b0;
    do_reset();
    cpu_read = 1'b1; hit = 1'b0;
    for (int c = 0; c < 4; c++) begin
      mem_ready = (c == 1) || (c == 2);
      @(negedge clk);
      tag_seen = tag_seen | tag_we;
      if (c == 3) begin
        total_cnt++;
        if (refill_word !== 2'd2) $display("FAIL midrst_word: got %0d expected 2", refill_word);
        else pass_cnt++;
        rst = 1'b1;
        #1 tag_seen = tag_seen | tag_we;
      end
      tick();
    end
    mem_ready = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    total_cnt++;
    if (tag_seen !== 1'b0) $display("FAIL midrst_tag: got %b expected 0", tag_seen);
    else pass_cnt++;
    cpu_read = 1'b1; hit = 1'b0;
    @(negedge clk);
    total_cnt++;
    if (outs_now() !== 6'b100000) $display("FAIL midrst_remiss: got %b expected 100000", outs_now());
    else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++;
    if (outs_now() !== 6'b110000 || refill_word !== 2'd0)
      $display("FAIL midrst_refill: got %b word=%0d expected 110000 word=0", outs_now(), refill_word);
    else pass_cnt++;
    tick();
    cpu_read = 1'b0;
  endtask

  task automatic test_perf();
    logic [3:0] seq[$];
    int e_hit, e_miss, e_wr;
    // each entry: {cpu_read, cpu_write, hit, mem_ready}
    seq = '{4'b1010, 4'b0000, 4'b1010, 4'b0000, 4'b1000,
            4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b1010,
            4'b0000, 4'b0110, 4'b0111, 4'b0000};
    do_reset();
    foreach (seq[i]) begin
      {cpu_read, cpu_write, hit, mem_ready} = seq[i];
      @(negedge clk);
      tick();
    end
    {cpu_read, cpu_write, hit, mem_ready} = 4'b0000;
    @(negedge clk);
`ifdef DCACHE_PERF_EN
    e_hit = 2; e_miss = 1; e_wr = 1;
`else
    e_hit = 0; e_miss = 0; e_wr = 0;
`endif
    total_cnt++;
    if (perf_rd_hit !== CW'(e_hit)) $display("FAIL perf_rd_hit: got %0d expected %0d", perf_rd_hit, e_hit);
    else pass_cnt++;
    total_cnt++;
    if (perf_rd_miss !== CW'(e_miss)) $display("FAIL perf_rd_miss: got %0d expected %0d", perf_rd_miss, e_miss);
    else pass_cnt++;
    total_cnt++;
    if (perf_wr !== CW'(e_wr)) $display("FAIL perf_wr: got %0d expected %0d", perf_wr, e_wr);
    else pass_cnt++;
    tick();
  endtask

  // Reference model: tracks which transaction is outstanding and how many words have arrived.
  typedef enum {M_IDLE, M_FILL, M_WR} mode_t;

  task automatic test_random();
    mode_t      mode, nmode;
    int         got;
    bit         after_fill, next_after;
    int         m_hits, m_miss, m_wr;
    logic [5:0] e_outs;
    logic [1:0] e_word;
    logic       rd, wr, h, rdy;
    int         e_hit, e_miss, e_wr;
    mode = M_IDLE; got = 0; after_fill = 0; m_hits = 0; m_miss = 0; m_wr = 0;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rd  = 1'($urandom_range(0, 1));
      wr  = ($urandom_range(0, 4) == 0);
      h   = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 2) == 0);
      cpu_read = rd; cpu_write = wr; hit = h; mem_ready = rdy;
      e_outs = 6'b0; e_word = 2'd0; nmode = mode; next_after = 0;
      case (mode)
        M_IDLE: begin
          if (wr) begin
            e_outs[5] = 1'b1; nmode = M_WR;
          end else if (rd && h) begin
            if (!after_fill) m_hits++;
          end else if (rd) begin
            e_outs[5] = 1'b1; nmode = M_FILL; got = 0; m_miss++;
          end
        end
        M_FILL: begin
          e_outs[5] = 1'b1; e_outs[4] = 1'b1; e_outs[2] = rdy;
          e_word = 2'(got % BW);
          if (rdy) begin
            got++;
            if (got == BW) begin
              e_outs[1] = 1'b1; nmode = M_IDLE; next_after = 1;
            end
          end
        end
        default: begin
          e_outs[3] = 1'b1; e_outs[5] = !rdy; e_outs[0] = rdy && h;
          if (rdy) begin
            m_wr++; nmode = M_IDLE;
          end
        end
      endcase
      @(negedge clk);
      total_cnt++;
      if (outs_now() !== e_outs) $display("FAIL rand_outs_%0d: got %b expected %b", n, outs_now(), e_outs);
      else pass_cnt++;
      total_cnt++;
      if (refill_word !== e_word) $display("FAIL rand_word_%0d: got %0d expected %0d", n, refill_word, e_word);
      else pass_cnt++;
      tick();
      mode = nmode; after_fill = next_after;
    end
    {cpu_read, cpu_write, hit, mem_ready} = 4'b0000;
    @(negedge clk);
`ifdef DCACHE_PERF_EN
    e_hit = m_hits; e_miss = m_miss; e_wr = m_wr;
`else
    e_hit = 0; e_miss = 0; e_wr = 0;
`endif
    total_cnt++;
    if (perf_rd_hit !== CW'(e_hit)) $display("FAIL rand_perf_hit: got %0d expected %0d", perf_rd_hit, e_hit);
    else pass_cnt++;
    total_cnt++;
    if (perf_rd_miss !== CW'(e_miss)) $display("FAIL rand_perf_miss: got %0d expected %0d", perf_rd_miss, e_miss);
    else pass_cnt++;
    total_cnt++;
    if (perf_wr !== CW'(e_wr)) $display("FAIL rand_perf_wr: got %0d expected %0d", perf_wr, e_wr);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_read_hit();
    test_read_miss();
    test_write(1'b1);
    test_write(1'b0);
    test_reset_mid_refill();
    test_perf();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
